// File: rtl/armleocpu_mem_1rw_ctrl_pkg.sv
// Shared types for the single-port SRAM request sequencer.
package armleocpu_mem_1rw_ctrl_pkg;

  typedef enum logic {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/armleocpu_mem_1rw.sv
// Single-port read-first SRAM cell, 1-cycle read latency, readdata held until the next read.
module armleocpu_mem_1rw #(
  parameter int ELEMENTS_W = 7,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic [ELEMENTS_W-1:0] address,
  input  logic                  read,
  output logic [WIDTH-1:0]      readdata,
  input  logic                  write,
  input  logic [WIDTH-1:0]      writedata
);

  logic [WIDTH-1:0] r_storage [2**ELEMENTS_W];

  // Read samples the old contents before a same-cycle write lands.
  always_ff @(posedge clk) begin
    if (read)
      readdata <= r_storage[address];
    if (write)
      r_storage[address] <= writedata;
  end

endmodule

// File: rtl/armleocpu_mem_1rw_ctrl.sv
// Request sequencer in front of armleocpu_mem_1rw: valid/ready requests in, cell strobes out,
// read responses served straight from the cell's held readdata; clears every entry after reset/flush.
//
// state  | meaning
// CLEAR  | sweeping INIT_VALUE into every entry, requests blocked
// ACTIVE | forwarding requests to the cell
module armleocpu_mem_1rw_ctrl
  import armleocpu_mem_1rw_ctrl_pkg::*;
#(
  parameter int               ELEMENTS_W     = 7,
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] INIT_VALUE     = {WIDTH{1'b0}},
  parameter bit               CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ELEMENTS_W-1:0] req_address,
  input  logic [WIDTH-1:0]      req_writedata,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_readdata,

  output logic [ELEMENTS_W-1:0] mem_address,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WIDTH-1:0]      mem_writedata,
  input  logic [WIDTH-1:0]      mem_readdata
);

  localparam logic [ELEMENTS_W-1:0] CNT_MAX = '1;
  localparam ctrl_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : ACTIVE;

  ctrl_state_t           r_state, w_state_nxt;
  logic [ELEMENTS_W-1:0] r_clear_cnt, w_clear_cnt_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  w_read_ok;
  logic                  w_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_clear_cnt <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clear_cnt <= w_clear_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_clear_cnt_nxt = r_clear_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_read_ok       = !r_rsp_valid || rsp_ready;
    w_fire          = 1'b0;
    req_ready       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = req_address;
    mem_writedata   = req_writedata;

    case (r_state)
      CLEAR: begin
        mem_write       = 1'b1;
        mem_address     = r_clear_cnt;
        mem_writedata   = INIT_VALUE;
        w_rsp_valid_nxt = 1'b0;
        w_clear_cnt_nxt = r_clear_cnt + 1'b1;
        if (r_clear_cnt == CNT_MAX) begin
          w_state_nxt     = ACTIVE;
          w_clear_cnt_nxt = '0;
        end
      end
      default: begin
        // A stalled response blocks reads only: the cell must keep holding its readdata.
        req_ready = !flush && (req_write || w_read_ok);
        w_fire    = req_valid && req_ready;
        mem_write = w_fire && req_write;
        mem_read  = w_fire && !req_write;
        if (mem_read)
          w_rsp_valid_nxt = 1'b1;
        else if (rsp_ready)
          w_rsp_valid_nxt = 1'b0;
      end
    endcase

    if (flush) begin
      w_state_nxt     = CLEAR;
      w_clear_cnt_nxt = '0;
      w_rsp_valid_nxt = 1'b0;
    end
  end

  assign busy         = (r_state == CLEAR);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_readdata = mem_readdata;

endmodule

// File: doc/armleocpu_mem_1rw_ctrl.md
Name: armleocpu_mem_1rw_ctrl

Overview:
Request sequencer that sits directly upstream of a single-port, read-first SRAM cell. The cell has 1-cycle read latency and holds readdata until the next read. This block converts a valid/ready request stream (read or write) into the cell's address/read/write/writedata strobes. It returns read data on a valid/ready response channel, using the cell's hold behaviour instead of a local data register. It also performs a hardware clear sweep of every entry (cache tag/valid arrays) after reset and on flush.

Parameters:
ELEMENTS_W, 7, address width; memory holds 2**ELEMENTS_W entries
WIDTH, 32, data width
INIT_VALUE, {WIDTH{1'b0}}, value written to every entry during clear sweep
CLEAR_ON_RESET, 1, 1: leave reset in CLEAR state; 0: leave reset in ACTIVE state

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  start (or restart) clear sweep
busy  output  1  1 while in CLEAR state
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_address  input  ELEMENTS_W  entry index
req_writedata  input  WIDTH  write data
rsp_valid  output  1  read response present
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_readdata  output  WIDTH  read data, equals mem_readdata
mem_address  output  ELEMENTS_W  to cell address
mem_read  output  1  to cell read
mem_write  output  1  to cell write
mem_writedata  output  WIDTH  to cell writedata
mem_readdata  input  WIDTH  from cell readdata

Behaviour:
- States: CLEAR, ACTIVE. Registers: state, clear_cnt[ELEMENTS_W-1:0], rsp_valid.
- Reset (async, rst_n=0): state=CLEAR if CLEAR_ON_RESET else ACTIVE; clear_cnt=0; rsp_valid=0. Hence busy=CLEAR_ON_RESET and req_ready=0 while in CLEAR.
- CLEAR: mem_write=1, mem_read=0, mem_address=clear_cnt, mem_writedata=INIT_VALUE, req_ready=0.
  - clear_cnt increments each cycle.
  - When clear_cnt == 2**ELEMENTS_W-1, go to ACTIVE next cycle and set clear_cnt=0.
  - The sweep takes exactly 2**ELEMENTS_W cycles.
- ACTIVE, combinational outputs:
  - read_ok = !rsp_valid || rsp_ready.
  - req_ready = !flush && (req_write || read_ok). Write readiness never depends on the response channel.
  - fire = req_valid && req_ready.
  - mem_address = req_address; mem_writedata = req_writedata.
  - mem_write = fire && req_write; mem_read = fire && !req_write.
- Read latency 1: read accepted in cycle N gives rsp_valid=1 in N+1, with rsp_readdata = cell contents as of the end of cycle N.
- rsp_valid next value: 1 if a read fires; else 0 if rsp_ready; else hold.
  - Back-to-back reads at full throughput while rsp_ready=1.
- Stalled response (rsp_valid && !rsp_ready):
  - No read is issued, so the cell holds readdata and rsp_readdata stays stable.
  - Writes are still accepted; because the cell is read-first, they do not disturb the held readdata, including a write to the same address.
- Write after read to the same address: the read returns old data. A read after a write in a later cycle returns new data.
- flush=1 (any state):
  - Next cycle is CLEAR with clear_cnt=0 and rsp_valid=0; a pending response is dropped.
  - flush during CLEAR restarts the sweep from 0.
  - No request fires in a flush cycle. In CLEAR the current cycle still performs its sweep write.
- mem_read and mem_write are never both 1.
- Invariant: the only reads issued are request-driven, so rsp_valid=1 implies that mem_readdata holds the last read.

Decomposition:
- Package armleocpu_mem_1rw_ctrl_pkg: state enum (CLEAR, ACTIVE) as a 1-bit localparam/typedef.
- No sub-module inside the block. Top-level integration and the bench instantiate armleocpu_mem_1rw next to it and connect the mem_* ports one-to-one.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ELEMENTS_W=3, INIT_VALUE=32'hDEAD_BEEF:
  - busy=1 for exactly 8 cycles, req_ready=0 during them.
  - Subsequent reads of addresses 0..7 all return 32'hDEAD_BEEF.
- Write addr 5 = 32'h1234_5678, then read addr 5 the next cycle -> rsp_valid=1 one cycle after acceptance, rsp_readdata=32'h1234_5678.
- Read addr 2 with rsp_ready=0 for 4 cycles, writing addr 2 = 32'hAAAA_AAAA during the stall:
  - Writes are accepted; read req_ready=0.
  - rsp_readdata stays at the old value until the handshake.
  - A following read of addr 2 returns 32'hAAAA_AAAA.
- Reads of addrs 0,1,2,3 in consecutive cycles with rsp_ready=1 -> 4 consecutive rsp_valid cycles with the matching data and no bubbles.
- flush asserted while rsp_valid=1 and rsp_ready=0:
  - rsp_valid=0 next cycle and busy=1 for 2**ELEMENTS_W cycles.
  - Contents equal INIT_VALUE afterwards.
- flush asserted mid-sweep at clear_cnt=3 -> clear_cnt restarts at 0; busy lasts 2**ELEMENTS_W cycles from the flush.
